m_lfsr_stream_gen: RTL

Parametrised M-sequence generator core, the successor to the fixed m_lfsr AXI4-Lite peripheral. It has a configurable LFSR width, a run-time programmable tap polynomial and seed, and a packed streaming output with valid/ready backpressure. A burst-length counter and a run/stop state machine control each run. The AXI4-Lite register file instantiates this core and drives its cfg_* and control ports directly.

---
 rtl/m_lfsr_stream_gen_if.sv | 20 ++
 rtl/m_lfsr_stream_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/m_lfsr_stream_gen_if.sv
// ---------------------------------------------------------------------------
// m_lfsr_stream_gen_if
// Stream bus carrying packed LFSR sequence beats from the generator core to
// a sink, with valid/ready backpressure.
//   tdata  [OUT_W] packed sequence bits, first-generated bit in bit 0
//   tvalid         beat valid (master -> slave)
//   tready         sink ready (slave -> master)
//   tlast          final beat of a finite or stopped run
// ---------------------------------------------------------------------------
interface m_lfsr_stream_gen_if #(
    parameter int OUT_W = 8
);
    logic [OUT_W-1:0] tdata;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/m_lfsr_stream_gen.sv
// ---------------------------------------------------------------------------
// m_lfsr_stream_gen
// M-sequence generator core: LFSR with run-time tap mask and seed, bits
// packed OUT_W per beat onto a valid/ready stream, with a burst-length
// counter and an IDLE/LOAD/RUN/DRAIN run control FSM.
//
// Ports:
//   ACLK, ARESET          clock, asynchronous active-high reset
//   cfg_poly/seed/len     tap mask, initial state, beats per run (0 = endless)
//                         all latched when a run is accepted
//   start, stop           single-cycle run control pulses
//   m_axis                stream master (tdata/tvalid/tlast out, tready in)
//   busy                  high in LOAD/RUN/DRAIN
//   done                  one-cycle pulse when a run ends or a start is refused
//   err_zero_seed         sticky, set by a start with a zero seed
//   lfsr_state            live LFSR register
//
// Optional build macro LFSR_PERIOD_CHECK_EN adds period_cnt/period_ok: the
// number of LFSR advances from LOAD until the state first returns to the seed,
// and whether that equals the maximal length 2^LFSR_W-1.
// ---------------------------------------------------------------------------
module m_lfsr_stream_gen #(
    parameter int LFSR_W = 32,
    parameter int OUT_W  = 8,
    parameter int LEN_W  = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic [LFSR_W-1:0] cfg_poly,
    input  logic [LFSR_W-1:0] cfg_seed,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              start,
    input  logic              stop,
    m_lfsr_stream_gen_if.master m_axis,
    output logic              busy,
    output logic              done,
    output logic              err_zero_seed,
    output logic [LFSR_W-1:0] lfsr_state
`ifdef LFSR_PERIOD_CHECK_EN
    ,
    output logic [LFSR_W-1:0] period_cnt,
    output logic              period_ok
`endif
);
    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

    state_t             r_fsm, w_fsm_nxt;
    logic [LFSR_W-1:0]  r_state, r_poly, r_seed;
    logic [LEN_W-1:0]   r_len, r_beat_cnt;
    logic [OUT_W-1:0]   r_shift, r_tdata, w_word;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_tvalid, r_tlast, r_done, r_err;

    logic               w_accept, w_word_pos, w_step, w_produce, w_is_last;
    logic               w_out_bit, w_fb, w_done_set, w_force_last;
    logic [LEN_W-1:0]   w_prod_num;

    assign w_out_bit  = r_state[LFSR_W-1];
    assign w_fb       = ^(r_state & r_poly);
    assign w_accept   = r_tvalid && m_axis.tready;
    assign w_word_pos = (r_bit_cnt == CNT_W'(OUT_W-1));
    // Bits keep flowing while a beat waits; only the bit that would complete
    // the next word is held back until the output slot frees up.
    assign w_step     = (r_fsm == S_RUN) && !stop &&
                        (!w_word_pos || !r_tvalid || m_axis.tready);
    assign w_produce  = w_step && w_word_pos;
    // Beat number being produced: accepted so far, plus one still pending.
    assign w_prod_num = r_beat_cnt + LEN_W'(r_tvalid) + LEN_W'(1);
    assign w_is_last  = (r_len != '0) && (w_prod_num == r_len);

    // Completed word: the bit generated this cycle lands at r_bit_cnt.
    always_comb begin
        w_word = r_shift;
        for (int b = 0; b < OUT_W; b++) begin
            if (CNT_W'(b) == r_bit_cnt) w_word[b] = w_out_bit;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) r_fsm <= S_IDLE;
        else        r_fsm <= w_fsm_nxt;
    end

    always_comb begin
        w_fsm_nxt    = r_fsm;
        w_done_set   = 1'b0;
        w_force_last = 1'b0;
        case (r_fsm)
            S_IDLE: begin
                if (start) begin
                    if (cfg_seed == '0) w_done_set = 1'b1;
                    else                w_fsm_nxt  = S_LOAD;
                end
            end
            S_LOAD: w_fsm_nxt = S_RUN;
            S_RUN: begin
                if (stop) begin
                    if (r_tvalid && !m_axis.tready) begin
                        w_fsm_nxt    = S_DRAIN;
                        w_force_last = 1'b1;
                    end else begin
                        w_fsm_nxt  = S_IDLE;
                        w_done_set = 1'b1;
                    end
                end else if (w_produce && w_is_last) begin
                    w_fsm_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_accept) begin
                    w_fsm_nxt  = S_IDLE;
                    w_done_set = 1'b1;
                end
            end
            default: w_fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state    <= '0;
            r_poly     <= '0;
            r_seed     <= '0;
            r_len      <= '0;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_beat_cnt <= '0;
            r_tdata    <= '0;
            r_tvalid   <= 1'b0;
            r_tlast    <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= w_done_set;
            if (r_fsm == S_IDLE && start) begin
                if (cfg_seed == '0) begin
                    r_err <= 1'b1;
                end else begin
                    r_err  <= 1'b0;
                    r_seed <= cfg_seed;
                    r_poly <= cfg_poly;
                    r_len  <= cfg_len;
                end
            end
            if (r_fsm == S_LOAD) begin
                r_state    <= r_seed;
                r_shift    <= '0;
                r_bit_cnt  <= '0;
                r_beat_cnt <= '0;
            end
            if (w_step) begin
                r_state            <= {r_state[LFSR_W-2:0], w_fb};
                r_shift[r_bit_cnt] <= w_out_bit;
                r_bit_cnt          <= w_word_pos ? '0 : r_bit_cnt + CNT_W'(1);
            end
            if (w_accept) begin
                r_tvalid   <= 1'b0;
                r_tlast    <= 1'b0;
                r_beat_cnt <= r_beat_cnt + LEN_W'(1);
            end
            // A new beat can only be produced into a free (or freeing) slot,
            // so it safely overrides the acceptance clear above.
            if (w_produce) begin
                r_tdata  <= w_word;
                r_tvalid <= 1'b1;
                r_tlast  <= w_is_last;
            end
            if (w_force_last) r_tlast <= 1'b1;
        end
    end

`ifdef LFSR_PERIOD_CHECK_EN
    logic [LFSR_W-1:0] r_step_cnt, r_period_cnt, w_step_inc;
    logic              r_period_ok, r_found;

    assign w_step_inc = r_step_cnt + LFSR_W'(1);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_step_cnt   <= '0;
            r_period_cnt <= '0;
            r_period_ok  <= 1'b0;
            r_found      <= 1'b0;
        end else begin
            if (r_fsm == S_IDLE && start) begin
                r_period_cnt <= '0;
                r_period_ok  <= 1'b0;
            end
            if (r_fsm == S_LOAD) begin
                r_step_cnt <= '0;
                r_found    <= 1'b0;
            end
            if (w_step && !r_found) begin
                r_step_cnt <= w_step_inc;
                if ({r_state[LFSR_W-2:0], w_fb} == r_seed) begin
                    r_period_cnt <= w_step_inc;
                    r_period_ok  <= (w_step_inc == '1);
                    r_found      <= 1'b1;
                end
            end
        end
    end

    assign period_cnt = r_period_cnt;
    assign period_ok  = r_period_ok;
`endif

    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign busy          = (r_fsm != S_IDLE);
    assign done          = r_done;
    assign err_zero_seed = r_err;
    assign lfsr_state    = r_state;
endmodule
